digser_mul: RTL

DIGSER_MUL -- requirements
Module: digser_mul

---
 rtl/digser_mul.sv | 90 +++++++++
 1 files changed

// File: rtl/digser_mul.sv
// Digit-serial unsigned multiplier: A*B, with B consumed DIGIT bits per cycle from the LSB.
// Optional macro DIGSER_MUL_SKIP_ZERO_EN ends the job as soon as no nonzero B digits remain.
module digser_mul #(
  parameter int LOGQ  = 60,
  parameter int DIGIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LOGQ-1:0]     A,
  input  logic [LOGQ-1:0]     B,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*LOGQ-1:0]   C
);
  localparam int LOGC = 2 * LOGQ;
  localparam int N    = LOGQ / DIGIT;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [LOGC-1:0]   r_acc;
  logic [LOGQ-1:0]   r_a;
  logic [LOGQ-1:0]   r_bsh;
  logic [LOGC-1:0]   w_pp, w_term;
  logic [LOGQ-1:0]   w_bsh_nxt;
  logic              w_last;
  logic              w_load;

  // Partial product is widened before multiplying so no high bits are lost.
  always_comb begin
    w_pp      = LOGC'(r_a) * LOGC'(r_bsh[DIGIT-1:0]);
    w_term    = w_pp << (32'(r_cnt) * DIGIT);
    w_bsh_nxt = r_bsh >> DIGIT;
`ifdef DIGSER_MUL_SKIP_ZERO_EN
    w_last    = (r_cnt == CW'(N-1)) || (w_bsh_nxt == '0);
`else
    w_last    = (r_cnt == CW'(N-1));
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
    // A handshake in DONE overrides the return to IDLE: back-to-back jobs.
    w_load = in_valid & in_ready;
    if (w_load) w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_bsh <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_a   <= A;
      r_bsh <= B;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= r_acc + w_term;
      r_bsh <= w_bsh_nxt;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign C = r_acc;

endmodule
